// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Entry fields are fixed at 32 bits; the fetch_unit parameters
    // ADDR_WIDTH and DATA_WIDTH are expected to stay at their default of 32.
    localparam int ENTRY_ADDR_W     = 32;
    localparam int ENTRY_DATA_W     = 32;
    localparam int FETCH_FIFO_DEPTH = 2;

    // addi x0, x0, 0 -- substituted for the data of any faulting fetch.
    localparam logic [ENTRY_DATA_W-1:0] NOP_INST = 32'h0000_0013;

    // One fetched instruction as handed to decode.
    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_ADDR_W-1:0] pc;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry buffer between the RAM response and decode.
// A flush empties it at the end of the cycle and overrides any push or pop.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [FETCH_FIFO_DEPTH];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    // Pointer and occupancy tracking; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // The credit scheme upstream guarantees a full buffer never sees a push.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && count_q == 2'(FETCH_FIFO_DEPTH)));
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the program RAM address,
// buffers the registered RAM response and presents it to decode.
//
// Handshake: inst_valid/inst_ready. An instruction transfers in any cycle
// where both are high; while inst_valid is high and inst_ready is low the
// inst_data/inst_pc/inst_fault outputs hold, and inst_valid never drops
// except on a redirect or reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    MEM_WORDS  = 750
) (
    input  logic                  clk,
    input  logic                  RESET,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault
);

    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS * 4);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic                  inflight_q;

    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         valid;
    logic         pop;
    logic         push;
    logic         issue;
    logic         req_fault;
    logic [2:0]   occupancy;

    assign valid = (count != 2'd0);
    assign pop   = valid & inst_ready;

    // A redirect takes effect on the address in the same cycle.
    assign mem_addr = RESET          ? RESET_PC :
                      redirect_valid ? redirect_pc : pc_q;

    // Credits in use after this cycle: buffered plus in flight minus the one
    // leaving. A redirect flushes everything, so all credits become free.
    always_comb begin
        occupancy = 3'd0;
        if (!redirect_valid) begin
            occupancy = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
        end
    end

    assign issue = !RESET && (occupancy < 3'(FETCH_FIFO_DEPTH));

    // The response for a request issued last cycle is dropped if a redirect
    // arrives with it.
    assign push = inflight_q && !redirect_valid && !RESET;

    assign req_fault = (req_pc_q[1:0] != 2'b00) || (req_pc_q >= MEM_LIMIT);

    // Build the entry for the returning response; faults carry a NOP.
    always_comb begin
        push_entry       = '0;
        push_entry.data  = req_fault ? NOP_INST : mem_rdata;
        push_entry.pc    = req_pc_q;
        push_entry.fault = req_fault;
    end

    // PC and outstanding-request tracking.
    always_ff @(posedge clk) begin
        if (RESET) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= mem_addr;
                pc_q     <= mem_addr + ADDR_WIDTH'(4);
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (RESET),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign inst_valid = valid;
    assign inst_data  = valid ? head.data  : '0;
    assign inst_pc    = valid ? head.pc    : '0;
    assign inst_fault = valid ? head.fault : 1'b0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the program block RAM. It owns the PC and drives the RAM word address. It captures the RAM read data, which is registered and returns one cycle after the address, and hands instructions to decode over a valid/ready handshake. It handles stalls through a 2-entry buffer and redirects (branch/jump) by flushing in-flight fetches. The RAM write port (WRE/byte enables) is not driven by this block and is tied inactive at the top level.

Parameters:
ADDR_WIDTH, 32, byte address width of PC and mem_addr
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset
MEM_WORDS, 750, number of 32-bit words in program RAM; bounds the legal fetch range

Ports:
clk  in  1  rising-edge clock
RESET  in  1  synchronous reset, active-high
mem_addr  out  ADDR_WIDTH  byte address presented to program RAM this cycle
mem_rdata  in  DATA_WIDTH  RAM read data for the address presented in the previous cycle
redirect_valid  in  1  load new PC and flush, single-cycle pulse
redirect_pc  in  ADDR_WIDTH  redirect target
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts
inst_data  out  DATA_WIDTH  instruction word
inst_pc  out  ADDR_WIDTH  PC of inst_data
inst_fault  out  1  fetch fault: misaligned or out-of-range PC

Behaviour:
- One clock (clk); RESET is synchronous and active-high and dominates all other inputs.
- Reset values: pc_q=RESET_PC, FIFO empty, inflight=0, inst_valid=0, inst_data=0, inst_pc=0, inst_fault=0. mem_addr=RESET_PC while in reset; no request is recorded.
- mem_addr is combinational: redirect_valid ? redirect_pc : pc_q.
- pop = inst_valid & inst_ready.
- Issue rule: issue = !RESET & (count + inflight - pop < 2).
- On issue, inflight_q<=1, req_pc_q<=mem_addr, and pc_q<=mem_addr+4. Otherwise inflight_q<=0 and pc_q holds.
- Response: when inflight_q=1 and the request was not killed, push {mem_rdata, req_pc_q, fault} into the FIFO in that cycle.
- Latency: an address issued in cycle t gives inst_valid in cycle t+2. Steady-state throughput is 1 instruction per cycle while inst_ready=1.
- FIFO: 2 entries. The head drives inst_*. Push and pop may occur in the same cycle. By construction it can never overflow; a push to a full FIFO is an assertion failure.
- Stall: while inst_valid=1 and inst_ready=0, inst_data, inst_pc and inst_fault must hold stable.
- Redirect, in cycle t:
  - The FIFO is cleared at the end of t.
  - The response arriving in t (from issue in t-1) is discarded.
  - redirect_pc is issued in t because all credits are free after the flush.
  - A pop in t still counts as accepted by decode.
  - The first valid instruction from redirect_pc appears at t+2.
- Fault on a fetch at a given PC:
  - Fault condition: pc[1:0]!=0 or pc >= MEM_WORDS*4.
  - The entry is pushed with inst_fault=1 and inst_data=32'h0000_0013 (NOP); mem_rdata is ignored.
  - Fetching continues at pc+4 until a redirect.
- PC wraps modulo 2^ADDR_WIDTH with no special handling; the range check flags it.
- Reset asserted mid-stream: FIFO and inflight are cleared at that edge. The first fetch is at RESET_PC in the cycle after RESET deasserts.

Decomposition:
- Package fetch_pkg: NOP_INST=32'h0000_0013, FETCH_FIFO_DEPTH=2, and a fetch entry struct {data, pc, fault}.
- One sub-module: fetch_skid_fifo (2-entry, synchronous flush input, push/pop/count).

Test Plan:
- Reset then inst_ready=1 held, RAM word i = 0x1000+i → inst_valid first high 2 cycles after RESET falls; pc 0,4,8… with data 0x1000,0x1001,… every cycle.
- inst_ready=0 for 5 cycles mid-stream → inst_valid held with pc=0x8 stable. After release, pcs 0x8,0xC,0x10 arrive with no gap, no duplicate, no loss.
- redirect_valid with redirect_pc=0x40 while 2 entries are buffered → buffered entries dropped; next inst_pc=0x40 two cycles later, then 0x44.
- redirect_pc=0x42 → inst_fault=1, inst_data=0x13, inst_pc=0x42; next entry is pc=0x46 with fault=1.
- Fetch reaching pc=750*4=0xBB8 → entry 0xBB4 has fault=0; entry 0xBB8 has fault=1 with NOP data.
- RESET asserted for 1 cycle while FIFO is full and inst_ready=0 → inst_valid=0 the next cycle; stream restarts at RESET_PC.
